// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch input stage: channel FSM encoding,
// default timing for the 1 MHz clock and a width helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_LOW  = 2'b00,
        ST_RISE = 2'b01,
        ST_HIGH = 2'b11,
        ST_FALL = 2'b10
    } btn_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 10000;
    localparam int unsigned DEF_LONG_CYCLES     = 1000000;

    // Smallest width whose range covers 0..v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: two-flop synchroniser, stable-time debounce FSM and hold timer
// producing a clean level plus registered press/release/long strobes.
//
// state | meaning
// LOW   | accepted level 0, input stable low
// RISE  | accepted level 0, input high for dcnt cycles
// HIGH  | accepted level 1, hold timer running
// FALL  | accepted level 1, input low for dcnt cycles, hold timer still running
module debounce_channel
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = clog2(DEBOUNCE_CYCLES),
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned HOLD_W          = clog2(LONG_CYCLES)
) (
    input  logic clk,
    input  logic res,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam logic [CNT_W-1:0]  D_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] H_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic              s1, s2;
    btn_state_t        state, state_nxt;
    logic [CNT_W-1:0]  dcnt, dcnt_nxt;
    logic [HOLD_W-1:0] hcnt, hcnt_nxt;
    logic              long_done, long_done_nxt;
    logic              level_nxt, press_nxt, release_nxt, long_nxt;
    logic              d_term, h_term, hold_active;

    assign d_term = (dcnt == D_LAST);
    assign h_term = (hcnt == H_LAST);
    // Hold time accrues in HIGH and FALL, except on the edge that accepts the release.
    assign hold_active = (state == ST_HIGH) || ((state == ST_FALL) && !(!s2 && d_term));

    always_ff @(posedge clk) begin
        if (res) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            state       <= ST_LOW;
            dcnt        <= '0;
            hcnt        <= '0;
            long_done   <= 1'b0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
        end else begin
            s1          <= btn_raw;
            s2          <= s1;
            state       <= state_nxt;
            dcnt        <= dcnt_nxt;
            hcnt        <= hcnt_nxt;
            long_done   <= long_done_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
            btn_long    <= long_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        dcnt_nxt      = dcnt;
        hcnt_nxt      = hcnt;
        long_done_nxt = long_done;
        if (hold_active && !long_done) begin
            if (h_term) long_done_nxt = 1'b1;
            else        hcnt_nxt = hcnt + HOLD_W'(1);
        end
        case (state)
            ST_LOW: begin
                hcnt_nxt      = '0;
                long_done_nxt = 1'b0;
                if (s2) begin
                    state_nxt = ST_RISE;
                    dcnt_nxt  = CNT_W'(1);
                end else begin
                    dcnt_nxt  = '0;
                end
            end
            ST_RISE: begin
                if (!s2) begin
                    state_nxt = ST_LOW;
                    dcnt_nxt  = '0;
                end else if (d_term) begin
                    state_nxt = ST_HIGH;
                    dcnt_nxt  = '0;
                    hcnt_nxt  = '0;
                end else begin
                    dcnt_nxt  = dcnt + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!s2) begin
                    state_nxt = ST_FALL;
                    dcnt_nxt  = CNT_W'(1);
                end else begin
                    dcnt_nxt  = '0;
                end
            end
            ST_FALL: begin
                if (s2) begin
                    state_nxt = ST_HIGH;
                    dcnt_nxt  = '0;
                end else if (d_term) begin
                    state_nxt     = ST_LOW;
                    dcnt_nxt      = '0;
                    hcnt_nxt      = '0;
                    long_done_nxt = 1'b0;
                end else begin
                    dcnt_nxt  = dcnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_LOW;
                dcnt_nxt  = '0;
                hcnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        press_nxt   = (state == ST_RISE) && s2 && d_term;
        release_nxt = (state == ST_FALL) && !s2 && d_term;
        long_nxt    = hold_active && !long_done && h_term;
        level_nxt   = btn_level;
        if (press_nxt)   level_nxt = 1'b1;
        if (release_nxt) level_nxt = 1'b0;
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-buttons into clk-domain levels and one-cycle
// press, release and long-press strobes; channels are fully independent.
module button_conditioner
    import stopwatch_pkg::*;
#(
    parameter int unsigned N_BTN           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = clog2(DEBOUNCE_CYCLES),
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned HOLD_W          = clog2(LONG_CYCLES)
) (
    input  logic             clk,
    input  logic             res,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .LONG_CYCLES     (LONG_CYCLES),
            .HOLD_W          (HOLD_W)
        ) u_ch (
            .clk         (clk),
            .res         (res),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_long    (btn_long[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length reference model checked every
// cycle, plus directed latency/bounce/long-press scenarios with literal timing.
module tb_button_conditioner;

    localparam int N = 3;
    localparam int D = 4;
    localparam int L = 20;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic [N-1:0] raw = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

    button_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk         (clk),
        .res         (res),
        .btn_raw     (raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: sample history, accepted level, length of the current disagreeing run,
    // and edges elapsed since the accepted press.
    logic [N-1:0] m_s1 = '0, m_s2 = '0;
    logic [N-1:0] m_level = '0, m_press = '0, m_release = '0, m_long = '0;
    int           m_run [N];
    int           m_age [N];
    int           edge_cnt = 0;

    initial for (int c = 0; c < N; c++) begin m_run[c] = 0; m_age[c] = 0; end

    always @(posedge clk) begin
        logic s2v;
        edge_cnt++;
        for (int c = 0; c < N; c++) begin
            m_press[c] = 1'b0; m_release[c] = 1'b0; m_long[c] = 1'b0;
            if (res) begin
                m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_level[c] = 1'b0;
                m_run[c] = 0; m_age[c] = 0;
            end else begin
                s2v = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = raw[c];
                if (s2v != m_level[c]) m_run[c]++;
                else m_run[c] = 0;
                if (m_run[c] == D) begin
                    m_run[c] = 0;
                    if (m_level[c]) begin
                        m_level[c] = 1'b0; m_release[c] = 1'b1;
                    end else begin
                        m_level[c] = 1'b1; m_press[c] = 1'b1; m_age[c] = 0;
                    end
                end else if (m_level[c]) begin
                    if (m_age[c] <= L) m_age[c]++;
                    if (m_age[c] == L) m_long[c] = 1'b1;
                end
            end
        end
    end

    int n_press [N], n_release [N], n_long [N];
    int e_press [N], e_release [N], e_long [N];

    initial for (int c = 0; c < N; c++) begin
        n_press[c] = 0; n_release[c] = 0; n_long[c] = 0;
        e_press[c] = 0; e_release[c] = 0; e_long[c] = 0;
    end

    always @(negedge clk) begin
        chk("level",   int'(btn_level),   int'(m_level));
        chk("press",   int'(btn_press),   int'(m_press));
        chk("release", int'(btn_release), int'(m_release));
        chk("long",    int'(btn_long),    int'(m_long));
        for (int c = 0; c < N; c++) begin
            if (btn_press[c])   begin n_press[c]++;   e_press[c]   = edge_cnt; end
            if (btn_release[c]) begin n_release[c]++; e_release[c] = edge_cnt; end
            if (btn_long[c])    begin n_long[c]++;    e_long[c]    = edge_cnt; end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_strobe(input int kind, input int ch, input int maxc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < maxc && !seen; k++) begin
            tick();
            case (kind)
                0:       seen = btn_press[ch];
                1:       seen = btn_release[ch];
                default: seen = btn_long[ch];
            endcase
        end
        if (!seen) begin
            total++;
            $display("FAIL wait_strobe kind=%0d ch=%0d: got none in %0d cycles, expected one", kind, ch, maxc);
        end
    endtask

    initial begin
        int cap, p0, r0, l0, pe;
        int hold [N];
        bit pat [8];

        // reset with all buttons held
        raw = 3'b111;
        repeat (3) begin
            tick();
            chk("rst_outputs", int'({btn_level, btn_press, btn_release, btn_long}), 0);
        end
        res = 1'b0;
        cap = edge_cnt + 1;
        wait_strobe(0, 0, 12);
        chk("rst_press_all", int'(btn_press), 7);
        chk("rst_level_all", int'(btn_level), 7);
        chk("rst_press_lat", e_press[0] - cap, 5);
        tick();
        chk("rst_press_width", int'(btn_press), 0);

        raw = '0;
        repeat (12) tick();

        // clean press on ch0
        r0 = n_release[0];
        raw[0] = 1'b1;
        cap = edge_cnt + 1;
        wait_strobe(0, 0, 12);
        chk("clean_press_lat", e_press[0] - cap, 5);
        chk("clean_level", int'(btn_level[0]), 1);
        tick();
        chk("clean_press_width", int'(btn_press[0]), 0);
        repeat (3) tick();
        chk("clean_no_release", n_release[0] - r0, 0);

        // bounce on ch1
        pat = '{1, 1, 1, 0, 1, 1, 1, 0};
        p0 = n_press[1];
        foreach (pat[i]) begin raw[1] = pat[i]; tick(); end
        repeat (6) tick();
        chk("bounce_no_press", n_press[1] - p0, 0);
        chk("bounce_level_low", int'(btn_level[1]), 0);
        raw[1] = 1'b1;
        repeat (6) tick();
        raw[1] = 1'b0;
        repeat (10) tick();
        chk("bounce_one_press", n_press[1] - p0, 1);

        // long press on ch2
        p0 = n_press[2]; r0 = n_release[2]; l0 = n_long[2];
        raw[2] = 1'b1;
        repeat (40) tick();
        raw[2] = 1'b0;
        repeat (10) tick();
        chk("long_once", n_long[2] - l0, 1);
        chk("long_lat", e_long[2] - e_press[2], 20);
        chk("long_release_once", n_release[2] - r0, 1);
        chk("long_press_once", n_press[2] - p0, 1);

        // release bounce on ch0, hold timer must survive the bounce
        raw[0] = 1'b0;
        repeat (10) tick();
        r0 = n_release[0]; l0 = n_long[0];
        raw[0] = 1'b1;
        wait_strobe(0, 0, 12);
        pe = e_press[0];
        repeat (12) tick();
        raw[0] = 1'b0; tick(); tick();
        raw[0] = 1'b1; tick();
        raw[0] = 1'b0;
        cap = edge_cnt + 1;
        repeat (10) tick();
        chk("relb_one_release", n_release[0] - r0, 1);
        chk("relb_release_lat", e_release[0] - cap, 5);
        chk("relb_long_once", n_long[0] - l0, 1);
        chk("relb_long_lat", e_long[0] - pe, 20);

        // reset mid-debounce on ch0
        p0 = n_press[0];
        raw[0] = 1'b1;
        repeat (4) tick();
        res = 1'b1;
        tick();
        chk("middeb_no_press", n_press[0] - p0, 0);
        chk("middeb_level", int'(btn_level[0]), 0);
        res = 1'b0;
        cap = edge_cnt + 1;
        wait_strobe(0, 0, 12);
        chk("middeb_press_lat", e_press[0] - cap, 5);
        chk("middeb_one_press", n_press[0] - p0, 1);

        // randomized bouncing buttons with occasional resets
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    raw[c] = ~raw[c];
                    hold[c] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 4))
                                                          : int'($urandom_range(5, 40));
                end else begin
                    hold[c]--;
                end
            end
            res = ($urandom_range(0, 599) == 0);
            tick();
        end
        res = 1'b0;
        raw = '0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
